// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - whack-a-mole round engine: hole pick, up/gap timing, hit/miss, score and lives
// Optional macro MOLE_SPEEDUP_EN shortens the up window every fourth hit, down to UP_MIN.
module mole_spawner #(
    parameter int HOLES     = 8,
    parameter int UP_TICKS  = 1000,
    parameter int GAP_TICKS = 300,
    parameter int LIVES     = 3,
    parameter int TW        = 12,
    parameter int UP_MIN    = 200,
    parameter int UP_STEP   = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [4:0]       rand_word,
    input  logic             start,
    input  logic [HOLES-1:0] btn,
    output logic [HOLES-1:0] mole,
    output logic             hit,
    output logic             miss,
    output logic [7:0]       score,
    output logic [2:0]       lives,
    output logic             game_over
);

    localparam int IW = $clog2(HOLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_UP,
        S_OVER
    } state_t;

    state_t           state;
    logic [HOLES-1:0] btn_prev;
    logic [HOLES-1:0] press;
    logic [TW-1:0]    timer;
    logic             expire;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    pick_raw;
    logic [IW-1:0]    pick;
    logic [7:0]       score_inc;
    logic [TW-1:0]    up_len;

    assign press    = btn & ~btn_prev;
    assign expire   = tick && (timer == TW'(1));
    assign pick_raw = IW'(rand_word % 5'(HOLES));

    // Never raise the same hole twice in a row.
    always_comb begin
        pick = pick_raw;
        if (pick_raw == last_idx) begin
            if (pick_raw == IW'(HOLES - 1))
                pick = '0;
            else
                pick = pick_raw + IW'(1);
        end
    end

    assign score_inc = (score == 8'hFF) ? score : score + 8'd1;

`ifndef MOLE_SPEEDUP_EN
    assign up_len = TW'(UP_TICKS);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mole      <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= 8'd0;
            lives     <= 3'(LIVES);
            game_over <= 1'b0;
            last_idx  <= '0;
            btn_prev  <= '0;
            timer     <= '0;
`ifdef MOLE_SPEEDUP_EN
            up_len    <= TW'(UP_TICKS);
`endif
        end else begin
            hit      <= 1'b0;
            miss     <= 1'b0;
            btn_prev <= btn;
            if (tick && timer != '0)
                timer <= timer - TW'(1);

            case (state)
                S_IDLE, S_OVER: begin
                    mole <= '0;
                    if (start) begin
                        state     <= S_GAP;
                        timer     <= TW'(GAP_TICKS);
                        score     <= 8'd0;
                        lives     <= 3'(LIVES);
                        game_over <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
                        up_len    <= TW'(UP_TICKS);
`endif
                    end
                end

                S_GAP: begin
                    mole <= '0;
                    if (expire) begin
                        last_idx <= pick;
                        mole     <= HOLES'(1) << pick;
                        timer    <= up_len;
                        state    <= S_UP;
                    end
                end

                S_UP: begin
                    // A press on the mole wins even if it lands on the expiry tick.
                    if ((press & mole) != '0) begin
                        hit   <= 1'b1;
                        score <= score_inc;
                        mole  <= '0;
                        timer <= TW'(GAP_TICKS);
                        state <= S_GAP;
`ifdef MOLE_SPEEDUP_EN
                        if (score != 8'hFF && score_inc[1:0] == 2'b00) begin
                            if (up_len >= TW'(UP_MIN + UP_STEP))
                                up_len <= up_len - TW'(UP_STEP);
                            else
                                up_len <= TW'(UP_MIN);
                        end
`endif
                    end else if (press != '0 || expire) begin
                        miss  <= 1'b1;
                        lives <= lives - 3'd1;
                        mole  <= '0;
                        if (lives == 3'd1) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            timer <= TW'(GAP_TICKS);
                            state <= S_GAP;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - directed self-checking bench for mole_spawner
module tb_mole_spawner;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [4:0] rand_word;
    logic       start;
    logic [7:0] btn;
    logic [7:0] mole;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;

    int passes = 0;
    int total  = 0;

`ifdef MOLE_SPEEDUP_EN
    localparam int UP2 = 3;
`else
    localparam int UP2 = 5;
`endif

    mole_spawner #(
        .HOLES(8), .UP_TICKS(5), .GAP_TICKS(3), .LIVES(3),
        .TW(12), .UP_MIN(2), .UP_STEP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rand_word(rand_word),
        .start(start), .btn(btn), .mole(mole), .hit(hit), .miss(miss),
        .score(score), .lives(lives), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

`ifdef MOLE_SPEEDUP_EN
    task automatic round_hit(input logic [4:0] r, input int exp_score);
        rand_word = r;
        step(3);
        check("su_mole", mole, 32'(8'd1 << r));
        btn = 8'd1 << r;
        step(1);
        check("su_hit", hit, 1);
        check("su_score", score, exp_score);
        btn = 8'h00;
    endtask

    task automatic round_miss(input logic [4:0] r, input int w, input int exp_lives);
        rand_word = r;
        step(3);
        check("su_miss_mole", mole, 32'(8'd1 << r));
        step(w - 1);
        check("su_still_up", mole, 32'(8'd1 << r));
        check("su_no_miss_early", miss, 0);
        step(1);
        check("su_miss", miss, 1);
        check("su_lives", lives, exp_lives);
    endtask
`endif

    initial begin
        rst_n = 1'b0; tick = 1'b1; rand_word = 5'h1D; start = 1'b0; btn = 8'h00;
        step(2);
        check("rst_mole", mole, 0);
        check("rst_score", score, 0);
        check("rst_lives", lives, 3);
        check("rst_over", game_over, 0);
        check("rst_pulses", {hit, miss}, 0);
        rst_n = 1'b1;
        step(1);

        start = 1'b1;
        step(1);
        start = 1'b0;
        check("gap_mole0", mole, 0);
        step(2);
        check("gap_mole2", mole, 0);
        step(1);
        check("first_mole", mole, 8'h20);
        check("first_score", score, 0);
        check("first_lives", lives, 3);

        step(1);
        btn = 8'h20;
        step(1);
        check("hit1", hit, 1);
        check("hit1_miss", miss, 0);
        check("hit1_score", score, 1);
        check("hit1_mole", mole, 0);
        btn = 8'h00;
        step(1);
        check("hit1_pulse_end", hit, 0);
        step(1);
        check("gap2_mole", mole, 0);
        step(1);
        check("repeat_idx_bump", mole, 8'h40);

        step(4);
        check("timeout_up", mole, 8'h40);
        check("timeout_early", miss, 0);
        step(1);
        check("timeout_miss", miss, 1);
        check("timeout_lives", lives, 2);
        check("timeout_mole", mole, 0);
        rand_word = 5'h02;
        step(1);
        check("timeout_pulse_end", miss, 0);
        step(2);
        check("mole_hole2", mole, 8'h04);

        btn = 8'h20;
        step(1);
        check("wrong_miss", miss, 1);
        check("wrong_hit", hit, 0);
        check("wrong_lives", lives, 1);
        btn = 8'h00;
        rand_word = 5'h1D;
        step(3);
        check("mole_hole5", mole, 8'h20);

        btn = 8'h24;
        step(1);
        check("multi_hit", hit, 1);
        check("multi_miss", miss, 0);
        check("multi_score", score, 2);
        check("multi_lives", lives, 1);
        rand_word = 5'h0A;
        step(3);
        check("held_mole", mole, 8'h04);
        step(2);
        check("held_no_hit", hit, 0);
        check("held_no_miss", miss, 0);
        check("held_mole_up", mole, 8'h04);
        btn = 8'h00;
        step(1);
        btn = 8'h04;
        step(1);
        check("repress_hit", hit, 1);
        check("repress_score", score, 3);
        btn = 8'h00;

        rand_word = 5'h1F;
        step(3);
        check("mole_hole7", mole, 8'h80);
        step(4);
        btn = 8'h80;
        step(1);
        check("expiry_hit", hit, 1);
        check("expiry_no_miss", miss, 0);
        check("expiry_score", score, 4);
        btn = 8'h00;

        rand_word = 5'h00;
        step(3);
        check("mole_hole0", mole, 8'h01);
        step(UP2 - 1);
        check("last_up", mole, 8'h01);
        step(1);
        check("last_miss", miss, 1);
        check("last_lives", lives, 0);
        check("over_flag", game_over, 1);
        check("over_mole", mole, 0);
        btn = 8'h01;
        step(2);
        check("over_hold", {game_over, lives, score, mole, hit, miss}, {1'b1, 3'd0, 8'd4, 8'd0, 2'b00});
        btn = 8'h00;

        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_over", game_over, 0);
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);
        tick = 1'b0;
        step(5);
        check("tick_pause", mole, 0);
        tick = 1'b1;
        step(3);
        check("restart_mole", mole, 8'h02);
        btn = 8'h02;
        step(1);
        check("pre_reset_hit", hit, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_hit", hit, 0);
        check("async_rst_score", score, 0);
        check("async_rst_lives", lives, 3);
        check("async_rst_mole", mole, 0);
        btn = 8'h00;
        step(1);
        rst_n = 1'b1;
        step(1);

`ifdef MOLE_SPEEDUP_EN
        start = 1'b1;
        step(1);
        start = 1'b0;
        round_hit(5'd3, 1);
        round_hit(5'd4, 2);
        round_hit(5'd3, 3);
        round_hit(5'd4, 4);
        round_miss(5'd3, 3, 2);
        round_hit(5'd4, 5);
        round_hit(5'd3, 6);
        round_hit(5'd4, 7);
        round_hit(5'd3, 8);
        round_miss(5'd4, 2, 1);
        round_hit(5'd3, 9);
        round_hit(5'd4, 10);
        round_hit(5'd3, 11);
        round_hit(5'd4, 12);
        round_miss(5'd3, 2, 0);
        check("su_over", game_over, 1);
        check("su_final_score", score, 12);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
